lock_code_entry: RTL and testbench
==================================

// Module: lock_code_entry
// PURPOSE
//  Keypad-side front end of the digital lock. Assembles BCD digits into a 16-bit entered code.
//  Holds the programmable stored code and issues unlock/fail/lockout decisions. It is the
//  producer of the code pair that the 16-bit equality compare consumes; compare is done
//  in-block (registered a==b). Sits between the keypad scanner and the door actuator/status LEDs.
// PARAMETERS
//  DEFAULT_CODE   16'h1234  stored code after reset (4 BCD digits, MS digit in [15:12])
//  MAX_TRIES      3         consecutive failures that trigger lockout (1..7)
//  LOCKOUT_CYCLES 1000      cycles spent in LOCKED (>=1)
//  UNLOCK_CYCLES  50        cycles unlock stays high (>=1)
// PORTS
//  clk        in   1   clock, all logic on posedge
//  rst        in   1   synchronous reset, active-high
//  key_valid  in   1   one-cycle strobe, key_code valid
//  key_code   in   4   0-9 digit; A=ENTER; B=CLEAR; C=PROG; D-F ignored
//  entry      out  16  digits shifted in so far (BCD)
//  digit_cnt  out  3   digits held, 0..4
//  unlock     out  1   high while OPEN
//  fail       out  1   one-cycle pulse on wrong/short code
//  locked     out  1   high while LOCKED
//  prog_done  out  1   one-cycle pulse when a new code is stored
// BEHAVIOUR
//  Reset: state IDLE; entry=0, digit_cnt=0, unlock=0, fail=0, locked=0, prog_done=0.
//   Also tries=0 and stored=DEFAULT_CODE. Reset mid-operation aborts everything,
//   including an unfinished PROG.
//  Digit key (ENTRY/PROG): entry<={entry[11:0],key_code}; digit_cnt++.
//   A 5th digit is ignored: entry and digit_cnt are unchanged.
//  CLEAR in IDLE/ENTRY/PROG: entry=0, digit_cnt=0. State: ENTRY->IDLE; PROG->OPEN.
//  States/transitions:
//   IDLE   : digit -> ENTRY (digit stored); ENTER/PROG/D-F ignored
//   ENTRY  : ENTER -> CHECK; CLEAR -> IDLE
//   CHECK  : 1 cycle; match = (digit_cnt==4) && (entry==stored)
//            match -> OPEN, tries=0; else -> FAIL, tries++
//   FAIL   : 1 cycle, fail=1; -> LOCKED if tries==MAX_TRIES else IDLE; entry/digit_cnt cleared
//   OPEN   : unlock=1 for UNLOCK_CYCLES, then -> IDLE
//            CLEAR -> IDLE immediately; PROG -> PROG (timer frozen, unlock stays 1)
//            entry/digit_cnt cleared on entry to OPEN
//   PROG   : ENTER with digit_cnt==4 -> stored<=entry, prog_done=1, -> IDLE (unlock drops)
//            ENTER with <4 digits -> fail pulse, -> OPEN, timer restarted; tries unaffected
//   LOCKED : locked=1, all keys ignored; after LOCKOUT_CYCLES -> IDLE, tries=0
//  Latency: ENTER at edge t -> CHECK at t+1; unlock or fail visible from t+2.
//  Keys during CHECK/FAIL/LOCKED are dropped, not queued. Non-BCD digits never enter entry.
//  Counters: timer wide enough for max(LOCKOUT_CYCLES,UNLOCK_CYCLES); no wrap (terminal compare).
// CONFIGURATION
//  LOCK_CODE_LOCKOUT_EN defined: tries counter + LOCKED state as above.
//  Undefined: no tries counter, FAIL always -> IDLE, locked tied 0, LOCKOUT_CYCLES unused.
// TESTING
//  1 reset; keys 1,2,3,4,A -> unlock=1 at ENTER+2, held 50 cycles, then 0.
//  2 keys 1,2,3,5,A -> fail pulse 1 cycle at ENTER+2; unlock stays 0; entry back to 0.
//  3 keys 1,2,A (short) -> fail; keys 1,2,3,4,5,A -> unlock (5th digit ignored).
//  4 (LOCKOUT_EN) 3 wrong codes -> locked=1 for 1000 cycles.
//    Code 1234 during lockout ignored; after lockout, correct code unlocks.
//  5 unlock; C,9,8,7,6,A -> prog_done pulse, unlock drops.
//    1234 now fails; 9876 unlocks. Reset -> 1234 valid again.
//  6 mid-entry 1,2,B,1,2,3,4,A -> unlock; assert rst during OPEN -> unlock=0 next cycle.

Source files
------------

// File: rtl/lock_code_entry.sv
// Keypad front end of the digital lock: BCD entry, stored code, unlock/fail/lockout decisions.
// Optional lockout (tries counter + LOCKED state) is built when LOCK_CODE_LOCKOUT_EN is defined.
module lock_code_entry #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned UNLOCK_CYCLES  = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] entry,
  output logic [2:0]  digit_cnt,
  output logic        unlock,
  output logic        fail,
  output logic        locked,
  output logic        prog_done
);

  localparam int unsigned TIMER_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES
                                                                       : UNLOCK_CYCLES;
  localparam int unsigned TW        = $clog2(TIMER_MAX + 1);
  localparam int unsigned CW        = 3;
  localparam logic [3:0]  KEY_ENTER = 4'hA;
  localparam logic [3:0]  KEY_CLEAR = 4'hB;
  localparam logic [3:0]  KEY_PROG  = 4'hC;

  // Parameter legality is checked at elaboration.
  if (MAX_TRIES == 0 || MAX_TRIES > 7) begin : g_bad_max_tries
    $error("lock_code_entry: MAX_TRIES must be 1..7");
  end
  if (UNLOCK_CYCLES == 0 || LOCKOUT_CYCLES == 0) begin : g_bad_cycles
    $error("lock_code_entry: UNLOCK_CYCLES and LOCKOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTRY  = 3'd1,
    S_CHECK  = 3'd2,
    S_FAIL   = 3'd3,
    S_OPEN   = 3'd4,
    S_PROG   = 3'd5,
    S_LOCKED = 3'd6
  } state_t;

  state_t          state, state_n;
  logic [15:0]     entry_n;
  logic [CW-1:0]   cnt_n;
  logic [TW-1:0]   timer, timer_n;
  logic [15:0]     stored, stored_n;
  logic            match_q;
  logic            fail_n, prog_done_n;

  logic is_digit, is_enter, is_clear, is_prog, can_shift;

`ifdef LOCK_CODE_LOCKOUT_EN
  logic [2:0] tries, tries_n;
`endif

  assign is_digit  = key_valid && (key_code <= 4'd9);
  assign is_enter  = key_valid && (key_code == KEY_ENTER);
  assign is_clear  = key_valid && (key_code == KEY_CLEAR);
  assign is_prog   = key_valid && (key_code == KEY_PROG);
  assign can_shift = is_digit && (digit_cnt < CW'(4));

  // Registered equality compare; entry is stable from the ENTER edge onward, so CHECK sees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= (digit_cnt == CW'(4)) && (entry == stored);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      entry     <= 16'h0000;
      digit_cnt <= '0;
      timer     <= '0;
      stored    <= DEFAULT_CODE;
      fail      <= 1'b0;
      prog_done <= 1'b0;
      unlock    <= 1'b0;
    end else begin
      state     <= state_n;
      entry     <= entry_n;
      digit_cnt <= cnt_n;
      timer     <= timer_n;
      stored    <= stored_n;
      fail      <= fail_n;
      prog_done <= prog_done_n;
      unlock    <= (state_n == S_OPEN) || (state_n == S_PROG);
    end
  end

`ifdef LOCK_CODE_LOCKOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tries  <= '0;
      locked <= 1'b0;
    end else begin
      tries  <= tries_n;
      locked <= (state_n == S_LOCKED);
    end
  end
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    entry_n     = entry;
    cnt_n       = digit_cnt;
    timer_n     = timer;
    stored_n    = stored;
    fail_n      = 1'b0;
    prog_done_n = 1'b0;
`ifdef LOCK_CODE_LOCKOUT_EN
    tries_n     = tries;
`endif

    case (state)
      S_IDLE: begin
        if (is_digit) begin
          entry_n = {12'h000, key_code};
          cnt_n   = CW'(1);
          state_n = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (is_enter) begin
          state_n = S_CHECK;
        end else if (is_clear) begin
          entry_n = 16'h0000;
          cnt_n   = '0;
          state_n = S_IDLE;
        end else if (can_shift) begin
          entry_n = {entry[11:0], key_code};
          cnt_n   = digit_cnt + CW'(1);
        end
      end

      S_CHECK: begin
        entry_n = 16'h0000;
        cnt_n   = '0;
        if (match_q) begin
          state_n = S_OPEN;
          timer_n = '0;
`ifdef LOCK_CODE_LOCKOUT_EN
          tries_n = '0;
`endif
        end else begin
          state_n = S_FAIL;
          fail_n  = 1'b1;
`ifdef LOCK_CODE_LOCKOUT_EN
          tries_n = tries + 3'd1;
`endif
        end
      end

      S_FAIL: begin
        state_n = S_IDLE;
`ifdef LOCK_CODE_LOCKOUT_EN
        if (tries >= 3'(MAX_TRIES)) begin
          state_n = S_LOCKED;
          timer_n = '0;
        end
`endif
      end

      // Keys take priority over the timeout; PROG freezes the timer.
      S_OPEN: begin
        if (is_clear) begin
          entry_n = 16'h0000;
          cnt_n   = '0;
          state_n = S_IDLE;
        end else if (is_prog) begin
          state_n = S_PROG;
        end else if (timer == TW'(UNLOCK_CYCLES - 1)) begin
          state_n = S_IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      S_PROG: begin
        if (is_enter) begin
          entry_n = 16'h0000;
          cnt_n   = '0;
          if (digit_cnt == CW'(4)) begin
            stored_n    = entry;
            prog_done_n = 1'b1;
            state_n     = S_IDLE;
          end else begin
            fail_n  = 1'b1;
            timer_n = '0;
            state_n = S_OPEN;
          end
        end else if (is_clear) begin
          entry_n = 16'h0000;
          cnt_n   = '0;
          state_n = S_OPEN;
        end else if (can_shift) begin
          entry_n = {entry[11:0], key_code};
          cnt_n   = digit_cnt + CW'(1);
        end
      end

`ifdef LOCK_CODE_LOCKOUT_EN
      S_LOCKED: begin
        if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
          state_n = S_IDLE;
          tries_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
`endif

      default: begin
        state_n = S_IDLE;
        entry_n = 16'h0000;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_lock_code_entry.sv
// Randomized bench for lock_code_entry against a digit-queue reference model of the lock rules.
module tb_lock_code_entry;

  localparam int DEF_CODE = 'h1234;
  localparam int UNLOCK_N = 50;
  localparam int LOCK_N   = 1000;
  localparam int TRIES_N  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic [2:0]  digit_cnt;
  logic        unlock, fail, locked, prog_done;

  always #5 clk = ~clk;

  lock_code_entry dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .entry     (entry),
    .digit_cnt (digit_cnt),
    .unlock    (unlock),
    .fail      (fail),
    .locked    (locked),
    .prog_done (prog_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: digits as a queue, time left as a countdown.
  typedef enum int {M_IDLE, M_ENTRY, M_CHECK, M_FAIL, M_OPEN, M_PROG, M_LOCKED} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_digits[$];
  int    m_stored = DEF_CODE;
  int    m_left   = 0;
  int    m_tries  = 0;
  bit    m_fail   = 0;
  bit    m_pd     = 0;
  bit    m_ready  = 0;

  function automatic int q_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  task automatic model_step(input bit r, input bit kv, input int k);
    bit digit, enter, clr, prg;
    if (r) begin
      m_mode = M_IDLE; m_digits.delete(); m_stored = DEF_CODE;
      m_left = 0; m_tries = 0; m_fail = 0; m_pd = 0; m_ready = 1;
      return;
    end
    m_fail = 0; m_pd = 0;
    digit = kv && k <= 9;
    enter = kv && k == 10;
    clr   = kv && k == 11;
    prg   = kv && k == 12;
    case (m_mode)
      M_IDLE: if (digit) begin m_digits.delete(); m_digits.push_back(k); m_mode = M_ENTRY; end
      M_ENTRY: begin
        if (enter) m_mode = M_CHECK;
        else if (clr) begin m_digits.delete(); m_mode = M_IDLE; end
        else if (digit && m_digits.size() < 4) m_digits.push_back(k);
      end
      M_CHECK: begin
        if (m_digits.size() == 4 && q_value() == m_stored) begin
          m_mode = M_OPEN; m_left = UNLOCK_N; m_tries = 0;
        end else begin
          m_mode = M_FAIL; m_fail = 1; m_tries++;
        end
        m_digits.delete();
      end
      M_FAIL: begin
        m_mode = M_IDLE;
`ifdef LOCK_CODE_LOCKOUT_EN
        if (m_tries >= TRIES_N) begin m_mode = M_LOCKED; m_left = LOCK_N; end
`endif
      end
      M_OPEN: begin
        if (clr) m_mode = M_IDLE;
        else if (prg) m_mode = M_PROG;
        else begin m_left--; if (m_left == 0) m_mode = M_IDLE; end
      end
      M_PROG: begin
        if (enter) begin
          if (m_digits.size() == 4) begin m_stored = q_value(); m_pd = 1; m_mode = M_IDLE; end
          else begin m_fail = 1; m_mode = M_OPEN; m_left = UNLOCK_N; end
          m_digits.delete();
        end else if (clr) begin
          m_digits.delete(); m_mode = M_OPEN;
        end else if (digit && m_digits.size() < 4) m_digits.push_back(k);
      end
      M_LOCKED: begin m_left--; if (m_left == 0) begin m_mode = M_IDLE; m_tries = 0; end end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // Single compare process: advance the model on each edge, check outputs just after.
  always @(posedge clk) begin
    model_step(rst, key_valid, int'(key_code));
    #1;
    if (m_ready) begin
      chk("entry", int'(entry), q_value());
      chk("digit_cnt", int'(digit_cnt), m_digits.size());
      chk("unlock", int'(unlock), int'(m_mode == M_OPEN || m_mode == M_PROG));
      chk("fail", int'(fail), int'(m_fail));
      chk("locked", int'(locked), int'(m_mode == M_LOCKED));
      chk("prog_done", int'(prog_done), int'(m_pd));
    end
  end

  task automatic press(input int k, input int gap);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(k);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic press_code(input int code, input int ndig, input bit with_enter);
    for (int i = ndig - 1; i >= 0; i--) press((code >> (4 * i)) & 15, 0);
    if (with_enter) press(10, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seq[5];
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_entry", int'(entry), 0);
    chk("rst_cnt", int'(digit_cnt), 0);
    chk("rst_unlock", int'(unlock), 0);

    // 1: correct code opens for exactly UNLOCK_N cycles
    press_code('h1234, 4, 1);
    chk("t1_check_closed", int'(unlock), 0);
    @(negedge clk);
    chk("t1_open", int'(unlock), 1);
    n = 0;
    while (unlock && n < 200) begin n++; @(negedge clk); end
    chk("t1_open_len", n, 50);

    // 2: wrong code -> one-cycle fail
    press_code('h1235, 4, 1);
    chk("t2_no_fail_yet", int'(fail), 0);
    @(negedge clk);
    chk("t2_fail", int'(fail), 1);
    chk("t2_entry_clr", int'(entry), 0);
    @(negedge clk);
    chk("t2_fail_pulse", int'(fail), 0);
    chk("t2_closed", int'(unlock), 0);

    // 3: short code fails; fifth digit ignored
    press_code('h12, 2, 1);
    @(negedge clk);
    chk("t3_short_fail", int'(fail), 1);
    @(negedge clk);
    press_code('h12345, 5, 0);
    chk("t3_entry", int'(entry), 'h1234);
    chk("t3_cnt", int'(digit_cnt), 4);
    press(10, 0);
    @(negedge clk);
    chk("t3_open", int'(unlock), 1);
    press(11, 0);
    chk("t3_clear_closes", int'(unlock), 0);

`ifdef LOCK_CODE_LOCKOUT_EN
    // 4: three failures lock for LOCK_N cycles; keys during lockout dropped
    for (int t = 0; t < 3; t++) begin
      press_code('h1111, 4, 1);
      repeat (2) @(negedge clk);
    end
    chk("t4_locked", int'(locked), 1);
    seq = '{1, 2, 3, 4, 10};
    n = 0;
    while (locked && n < 2000) begin
      n++;
      key_valid = (n >= 3 && n < 8);
      key_code  = 4'(seq[(n >= 3 && n < 8) ? n - 3 : 0]);
      @(negedge clk);
    end
    key_valid = 1'b0;
    chk("t4_lock_len", n, 1000);
    chk("t4_still_closed", int'(unlock), 0);
    press_code('h1234, 4, 1);
    @(negedge clk);
    chk("t4_open_after", int'(unlock), 1);
    press(11, 0);
`endif

    // 5: reprogram the code from OPEN
    press_code('h1234, 4, 1);
    @(negedge clk);
    press(12, 0);
    chk("t5_prog_unlock", int'(unlock), 1);
    press_code('h9876, 4, 1);
    chk("t5_prog_done", int'(prog_done), 1);
    chk("t5_unlock_drop", int'(unlock), 0);
    @(negedge clk);
    chk("t5_pd_pulse", int'(prog_done), 0);
    press_code('h1234, 4, 1);
    @(negedge clk);
    chk("t5_old_fails", int'(fail), 1);
    @(negedge clk);
    press_code('h9876, 4, 1);
    @(negedge clk);
    chk("t5_new_opens", int'(unlock), 1);
    do_reset();
    press_code('h1234, 4, 1);
    @(negedge clk);
    chk("t5_default_back", int'(unlock), 1);
    press(11, 0);

    // 6: clear mid-entry, then reset during OPEN
    press(1, 0); press(2, 0); press(11, 0);
    press_code('h1234, 4, 1);
    @(negedge clk);
    chk("t6_open", int'(unlock), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_closes", int'(unlock), 0);
    rst = 1'b0;

    // Random traffic
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: press_code(m_stored, 4, 1);
        3: press_code(int'($urandom_range(0, 'h9999)), 4, 1);
        4: press_code(int'($urandom_range(0, 'h99)), $urandom_range(0, 3), 1);
        5: begin
          press(12, $urandom_range(0, 1));
          for (int d = 0; d < int'($urandom_range(2, 5)); d++)
            press($urandom_range(0, 9), $urandom_range(0, 1));
          press(10, 0);
        end
        6: for (int d = 0; d < 6; d++) press($urandom_range(0, 15), $urandom_range(0, 2));
        7: press(11, $urandom_range(0, 3));
        8: repeat ($urandom_range(0, 60)) @(negedge clk);
        default: if ($urandom_range(0, 2) == 0) do_reset();
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
